dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-ported data memory between the CPU load/store unit (port 0) and a secondary master such as a DMA or peripheral bridge (port 1). Each requester issues a single word access with a req/ack handshake. The arbiter selects one winner, drives the memory for exactly one cycle, and returns registered read data with a one-cycle ack pulse. It sits between the datapath's MEM stage / peripheral bus and the data memory's rd/wr/addr/wdata/rdata pins.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req0`, `req1` in 1: request from port 0 / port 1; held high until the matching ack.
- `rd0`, `rd1` in 1: read access.
- `wr0`, `wr1` in 1: write access.
- `addr0`, `addr1` in ADDR_W: byte address, word aligned.
- `wdata0`, `wdata1` in DATA_W: write data.
- `ack0`, `ack1` out 1: one-cycle completion pulse.
- `rdata0`, `rdata1` out DATA_W: read result; valid with ack, held until that port's next ack.
- `mem_rd`, `mem_wr` out 1: memory strobes.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory combinational read data.

## Operation
- FSM states: IDLE, ACC, ACK.
- IDLE: if any req is high, pick a winner and capture its rd/wr/addr/wdata into internal registers; capture the winner index. Next state is ACC. If no req is high, stay in IDLE.
- ACC: drive `mem_rd`/`mem_wr`/`mem_addr`/`mem_wdata` from the captured registers. A write commits at the closing edge. On a read, `mem_rdata` is latched into the winner's rdata register at the closing edge. Next state is ACK.
- ACK: assert the winner's ack for this cycle only, and update last_grant to the winner. Next state is IDLE unconditionally. The served req is ignored during ACK.
- Outside ACC, all `mem_*` outputs are 0.
- rd and wr both high: treated as a write. The port's rdata is set to 0.
- Neither rd nor wr: no-op. No memory strobe, rdata is set to 0, and ack is still given.
- A requester must deassert req, or present a new request, in the cycle after ack. Changing addr/wdata while req is high before ack is a protocol violation; the values captured in IDLE are used.
- Single requester: it wins regardless of priority.
- Both requesting in IDLE: the winner is decided by the tie rule in Configuration.
- Reset (any time, including mid-ACC): state goes to IDLE; acks, `mem_*` and both rdata registers go to 0; captured registers go to 0; last_grant goes to 1. An in-flight write at reset is dropped.

## Timing
- Request sampled in cycle N (IDLE) → memory access in N+1 → ack and rdata valid in N+2.
- Fixed 3-cycle occupancy per transaction; peak throughput is one access per 3 cycles.
- Back-to-back: port 1 held while port 0 is served → port 1 enters ACC at N+4.
- Reset values: `ack0`=`ack1`=0, `rdata0`=`rdata1`=0, `mem_rd`=`mem_wr`=0, `mem_addr`=0, `mem_wdata`=0.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin tie-break. On a tie, the port not equal to last_grant wins. After reset, port 0 wins the first tie.
- `DMEM_ARB_RR_EN` undefined: fixed priority. Port 0 always wins ties, and last_grant is unused. Port 1 can starve under continuous port 0 traffic; this is accepted.

## Structure
- Package `dmem_arb_pkg`: FSM state enum (IDLE/ACC/ACK), port index constants `PORT_CPU`=0 and `PORT_AUX`=1, and the captured-request struct (rd, wr, addr, wdata).
- Sub-module `dmem_arb_pick2`: combinational winner select from req0, req1, last_grant and the mode; outputs grant index and a valid flag. It isolates the `DMEM_ARB_RR_EN` logic.

## Test plan
- Single read: memory word 0x10 = 0xDEADBEEF; req0 with rd0, addr0=0x10 at cycle N → `mem_rd`=1 and `mem_addr`=0x10 at N+1 only; ack0=1 and rdata0=0xDEADBEEF at N+2.
- Write then read: port 1 writes 0x12345678 to 0x20, then reads 0x20 → ack1 for each, and rdata1=0x12345678.
- Simultaneous requests with RR: req0 and req1 held continuously from reset → grants alternate 0,1,0,1. Without the macro: port 0 is served every transaction and ack1 never fires while req0 stays high.
- rd+wr together: rd0=wr0=1, wdata0=0xA5A5A5A5, addr0=0x8 → `mem_wr`=1 and `mem_rd`=0 in ACC; rdata0=0 at ack; a later read of 0x8 returns 0xA5A5A5A5.
- Reset in ACC during a port 0 write to 0x4 → all outputs 0 next cycle; state IDLE; word 0x4 unchanged.
- No-op request: req1=1 with rd1=wr1=0 → no `mem_*` strobe; ack1 at N+2; rdata1=0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    // Captured fields are stored at the widest supported width; the top slices
    // them back down to its ADDR_W/DATA_W (both must be <= 64).
    localparam int CAP_ADDR_W = 64;
    localparam int CAP_DATA_W = 64;

    typedef struct packed {
        logic                  rd;
        logic                  wr;
        logic [CAP_ADDR_W-1:0] addr;
        logic [CAP_DATA_W-1:0] wdata;
    } cap_req_t;

    // rd together with wr is treated as a write, so only a pure rd reads.
    function automatic logic is_read(input cap_req_t r);
        return r.rd && !r.wr;
    endfunction

endpackage

// File: rtl/dmem_arb_pick2.sv
// Combinational winner select for two requesters.
// DMEM_ARB_RR_EN selects round-robin tie-break; otherwise port 0 wins ties.
module dmem_arb_pick2
    import dmem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant,
    output logic valid
);

    assign valid = req0 | req1;

`ifdef DMEM_ARB_RR_EN
    always_comb begin
        grant = PORT_CPU;
        if (req0 && req1) begin
            grant = ~last_grant;
        end else if (req1) begin
            grant = PORT_AUX;
        end
    end
`else
    // Fixed priority has no use for grant history.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant = PORT_CPU;
        if (!req0 && req1) begin
            grant = PORT_AUX;
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing a single-ported data memory; one access per 3 cycles.
// Tie-break mode: DMEM_ARB_RR_EN defined = round-robin, undefined = port 0 priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              rd0,
    input  logic              wr0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              rd1,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output state_t            fsm_state
);

    state_t            state;
    state_t            state_next;
    cap_req_t          cap_q;
    cap_req_t          cap_sel;
    logic              win_q;
    logic              last_grant_q;
    logic              grant;
    logic              grant_valid;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    // Upper capture bits beyond ADDR_W/DATA_W are always zero.
    logic unused_cap;
    assign unused_cap = ^{cap_q.addr, cap_q.wdata};

    dmem_arb_pick2 u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant_q),
        .grant      (grant),
        .valid      (grant_valid)
    );

    always_comb begin
        cap_sel.rd    = rd0;
        cap_sel.wr    = wr0;
        cap_sel.addr  = CAP_ADDR_W'(addr0);
        cap_sel.wdata = CAP_DATA_W'(wdata0);
        if (grant == PORT_AUX) begin
            cap_sel.rd    = rd1;
            cap_sel.wr    = wr1;
            cap_sel.addr  = CAP_ADDR_W'(addr1);
            cap_sel.wdata = CAP_DATA_W'(wdata1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        ack0       = 1'b0;
        ack1       = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_next = ACC;
                end
            end
            ACC: begin
                state_next = ACK;
                mem_wr     = cap_q.wr;
                mem_rd     = is_read(cap_q);
                // A no-op keeps the bus fully quiet, address included.
                if (cap_q.rd || cap_q.wr) begin
                    mem_addr = cap_q.addr[ADDR_W-1:0];
                end
                if (cap_q.wr) begin
                    mem_wdata = cap_q.wdata[DATA_W-1:0];
                end
            end
            ACK: begin
                state_next = IDLE;
                ack0       = (win_q == PORT_CPU);
                ack1       = (win_q == PORT_AUX);
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_q        <= '0;
            win_q        <= PORT_CPU;
            last_grant_q <= PORT_AUX;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        cap_q <= cap_sel;
                        win_q <= grant;
                    end
                end
                ACC: begin
                    // Writes and no-ops return zero read data.
                    if (win_q == PORT_CPU) begin
                        rdata0_q <= is_read(cap_q) ? mem_rdata : '0;
                    end else begin
                        rdata1_q <= is_read(cap_q) ? mem_rdata : '0;
                    end
                end
                ACK: begin
                    last_grant_q <= win_q;
                end
                default: begin
                end
            endcase
        end
    end

    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-ported memory.
// Honours DMEM_ARB_RR_EN when checking tie-break order.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic        clk;
    logic        reset;
    logic        req0, rd0, wr0;
    logic [31:0] addr0, wdata0;
    logic        req1, rd1, wr1;
    logic [31:0] addr1, wdata1;
    logic        ack0, ack1;
    logic [31:0] rdata0, rdata1;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    state_t      fsm_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [0:63];

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .rd0       (rd0),
        .wr0       (wr0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .req1      (req1),
        .rd1       (rd1),
        .wr1       (wr1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .fsm_state (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic port, input logic req, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 1'b0) begin
            req0 = req; rd0 = rd; wr0 = wr; addr0 = addr; wdata0 = wdata;
        end else begin
            req1 = req; rd1 = rd; wr1 = wr; addr1 = addr; wdata1 = wdata;
        end
    endtask

    // One transaction on a single port with the other port idle.
    task automatic xfer(input string tag, input logic port, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata);
        logic exp_rd;
        logic exp_wr;
        exp_wr = wr;
        exp_rd = rd && !wr;
        @(negedge clk);
        drive(port, 1'b1, rd, wr, addr, wdata);
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".acc_state"}, 64'(fsm_state), 64'(ACC));
        chk({tag, ".mem_rd"}, 64'(mem_rd), 64'(exp_rd));
        chk({tag, ".mem_wr"}, 64'(mem_wr), 64'(exp_wr));
        chk({tag, ".mem_addr"}, 64'(mem_addr), (exp_rd || exp_wr) ? 64'(addr) : 64'h0);
        chk({tag, ".early_ack"}, 64'({ack1, ack0}), 64'h0);
        if (exp_wr) chk({tag, ".mem_wdata"}, 64'(mem_wdata), 64'(wdata));
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".ack0"}, 64'(ack0), 64'(port == 1'b0));
        chk({tag, ".ack1"}, 64'(ack1), 64'(port == 1'b1));
        chk({tag, ".rdata"}, (port == 1'b0) ? 64'(rdata0) : 64'(rdata1), 64'(exp_rdata));
        chk({tag, ".ack_strobes"}, 64'({mem_rd, mem_wr}), 64'h0);
        drive(port, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".idle_state"}, 64'(fsm_state), 64'(IDLE));
        chk({tag, ".ack_clear"}, 64'({ack1, ack0}), 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic exp_win;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4] = 32'hDEADBEEF;
        mem[1] = 32'h11111111;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        repeat (2) @(negedge clk);
        chk("rst.state", 64'(fsm_state), 64'(IDLE));
        chk("rst.acks", 64'({ack1, ack0}), 64'h0);
        chk("rst.rdata0", 64'(rdata0), 64'h0);
        chk("rst.rdata1", 64'(rdata1), 64'h0);
        chk("rst.strobes", 64'({mem_rd, mem_wr}), 64'h0);
        chk("rst.mem_addr", 64'(mem_addr), 64'h0);
        chk("rst.mem_wdata", 64'(mem_wdata), 64'h0);
        reset = 1'b0;

        xfer("rd0", 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
        xfer("wr1", 1'b1, 1'b0, 1'b1, 32'h20, 32'h12345678, 32'h0);
        chk("wr1.mem_word", 64'(mem[8]), 64'h12345678);
        xfer("rd1", 1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 32'h12345678);

        // Port 1 arrives while port 0 is in flight; it reaches ACC four cycles later.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
        chk("b2b.acc0_addr", 64'(mem_addr), 64'h10);
        @(posedge clk);
        @(negedge clk);
        chk("b2b.ack0", 64'({ack1, ack0}), 64'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b.idle", 64'(fsm_state), 64'(IDLE));
        chk("b2b.idle_rd", 64'(mem_rd), 64'h0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b.acc1_state", 64'(fsm_state), 64'(ACC));
        chk("b2b.acc1_addr", 64'(mem_addr), 64'h20);
        chk("b2b.acc1_rd", 64'(mem_rd), 64'h1);
        @(posedge clk);
        @(negedge clk);
        chk("b2b.ack1", 64'({ack1, ack0}), 64'h2);
        chk("b2b.rdata1", 64'(rdata1), 64'h12345678);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);

        xfer("rdwr0", 1'b0, 1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, 32'h0);
        xfer("rd0_8", 1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 32'hA5A5A5A5);
        xfer("nop1", 1'b1, 1'b0, 1'b0, 32'h30, 32'h0, 32'h0);

        // Reset arrives mid-ACC during a write; the write must be dropped.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h4, 32'hCAFEF00D);
        @(posedge clk);
        @(negedge clk);
        chk("rstacc.mem_wr", 64'(mem_wr), 64'h1);
        #2 reset = 1'b1;
        #1;
        chk("rstacc.state", 64'(fsm_state), 64'(IDLE));
        chk("rstacc.strobes", 64'({mem_rd, mem_wr}), 64'h0);
        chk("rstacc.mem_addr", 64'(mem_addr), 64'h0);
        chk("rstacc.mem_wdata", 64'(mem_wdata), 64'h0);
        chk("rstacc.rdata0", 64'(rdata0), 64'h0);
        chk("rstacc.acks", 64'({ack1, ack0}), 64'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("rstacc.word4", 64'(mem[1]), 64'h11111111);

        // Both ports request continuously from reset release.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_RR_EN
            exp_win = k[0];
`else
            exp_win = 1'b0;
`endif
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("tie%0d.acc", k), 64'(fsm_state), 64'(ACC));
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("tie%0d.ack0", k), 64'(ack0), 64'(exp_win == 1'b0));
            chk($sformatf("tie%0d.ack1", k), 64'(ack1), 64'(exp_win == 1'b1));
            if (exp_win) chk($sformatf("tie%0d.rdata1", k), 64'(rdata1), 64'h12345678);
            else         chk($sformatf("tie%0d.rdata0", k), 64'(rdata0), 64'hDEADBEEF);
            if (k == 3) begin
                drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
                drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            end
            @(posedge clk);
        end
        @(negedge clk);
        chk("tie.final_idle", 64'(fsm_state), 64'(IDLE));
        chk("tie.final_acks", 64'({ack1, ack0}), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
